regfile_sequencer: RTL and testbench

Multi-cycle instruction sequencer that owns the control side of the 8×8-bit register file: it accepts one 16-bit instruction at a time over a valid/ready handshake and drives the register file's read selects, write select, load strobe and write data. It reads operands, executes an 8-bit ALU operation, and writes the result back. It sits between the instruction source (fetch/test host) and the register file; it is the only driver of the register file's SA, SB, LD, DR and D_in.

---
 rtl/regfile_seq_pkg.sv | 45 ++++
 rtl/regfile_sequencer_alu.sv | 65 ++++++
 rtl/regfile_sequencer.sv | 131 +++++++++++++
 tb/tb_regfile_sequencer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file instruction sequencer.
//   - opcode constants
//   - FSM state encoding
//   - instruction field positions
//   - opcode classification helpers
package regfile_seq_pkg;

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_MOV = 4'd1;
  localparam logic [3:0] OP_ADD = 4'd2;
  localparam logic [3:0] OP_SUB = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_OR  = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_LDI = 4'd7;
  localparam logic [3:0] OP_SHL = 4'd8;
  localparam logic [3:0] OP_SHR = 4'd9;

  // Instruction field positions (MSB of each field)
  localparam int OP_MSB   = 15;
  localparam int DEST_MSB = 11;
  localparam int SRCA_MSB = 8;
  localparam int SRCB_MSB = 5;
  localparam int IMM_MSB  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_EXEC  = 2'd2,
    ST_WRITE = 2'd3
  } state_t;

  // Opcodes that produce a flag-updating ALU result.
  function automatic logic is_alu_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
           (op == OP_OR)  || (op == OP_XOR) || (op == OP_SHL) ||
           (op == OP_SHR);
  endfunction

  // Opcodes that write a destination register (everything legal but NOP).
  function automatic logic writes_reg(input logic [3:0] op);
    return (op != OP_NOP) && (op <= OP_SHR);
  endfunction

endpackage

// File: rtl/regfile_sequencer_alu.sv
// seq_alu: combinational 8-bit ALU for the register-file sequencer.
// Ports:
//   op            in  4  opcode
//   a, b          in  8  captured operands
//   imm           in  8  immediate (LDI)
//   result        out 8  operation result (0 for NOP/illegal)
//   carry         out 1  carry / borrow / shifted-out bit, 0 for logic ops
//   updates_flags out 1  op is one that updates Z/C
//   illegal       out 1  opcode outside the defined set
module seq_alu
  import regfile_seq_pkg::*;
(
  input  logic [3:0] op,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] imm,
  output logic [7:0] result,
  output logic       carry,
  output logic       updates_flags,
  output logic       illegal
);

  logic [8:0] sum;
  logic [8:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // Bit 8 of the 9-bit difference is set exactly when a < b.
  assign diff = {1'b0, a} - {1'b0, b};

  assign updates_flags = is_alu_op(op);
  assign illegal       = (op > OP_SHR);

  always_comb begin
    result = 8'h00;
    carry  = 1'b0;
    case (op)
      OP_MOV: result = a;
      OP_ADD: begin
        result = sum[7:0];
        carry  = sum[8];
      end
      OP_SUB: begin
        result = diff[7:0];
        carry  = diff[8];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_LDI: result = imm;
      OP_SHL: begin
        result = {a[6:0], 1'b0};
        carry  = a[7];
      end
      OP_SHR: begin
        result = {1'b0, a[7:1]};
        carry  = a[0];
      end
      default: begin
        result = 8'h00;
        carry  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: multi-cycle sequencer driving the control side of an
// 8x8-bit register file. One instruction per valid/ready handshake, then
// READ (selects out) -> EXEC (operands held) -> WRITE (LD/DONE, result out).
// Ports:
//   CLK, RESET_N          clock, async active-low reset
//   INSTR, INSTR_VALID    instruction input, INSTR_READY back-pressure
//   SA, SB, DR            register file read/write selects
//   LD, D_OUT             register file load strobe and write data
//   DATA_A, DATA_B        register file combinational read data
//   DONE, ERR             retire pulse, illegal-opcode pulse
//   FLAG_Z, FLAG_C        zero / carry flags
//
// state | meaning
// IDLE  | waiting for an instruction, ready
// READ  | SA/SB driven, register file data valid at end of cycle
// EXEC  | operands held, ALU result captured at end of cycle
// WRITE | LD/DONE/ERR asserted, ready for next instruction
module regfile_sequencer
  import regfile_seq_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [15:0] INSTR,
  input  logic        INSTR_VALID,
  output logic        INSTR_READY,
  output logic [2:0]  SA,
  output logic [2:0]  SB,
  output logic [2:0]  DR,
  output logic        LD,
  output logic [7:0]  D_OUT,
  input  logic [7:0]  DATA_A,
  input  logic [7:0]  DATA_B,
  output logic        DONE,
  output logic        FLAG_Z,
  output logic        FLAG_C,
  output logic        ERR
);

  state_t     state_q, state_d;
  logic [3:0] op_q;
  logic [7:0] imm_q;
  logic [2:0] sa_q, sb_q, dr_q;
  logic [7:0] opa_q, opb_q;
  logic [7:0] dout_q;
  logic       fz_q, fc_q;

  logic       hs;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       alu_upd;
  logic       alu_illegal;

  assign INSTR_READY = (state_q == ST_IDLE) || (state_q == ST_WRITE);
  assign hs          = INSTR_VALID && INSTR_READY;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (hs) state_d = ST_READ;
      ST_READ:  state_d = ST_EXEC;
      ST_EXEC:  state_d = ST_WRITE;
      ST_WRITE: state_d = hs ? ST_READ : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  seq_alu u_alu (
    .op            (op_q),
    .a             (opa_q),
    .b             (opb_q),
    .imm           (imm_q),
    .result        (alu_result),
    .carry         (alu_carry),
    .updates_flags (alu_upd),
    .illegal       (alu_illegal)
  );

  // Selects are loaded straight from INSTR at the handshake so they are
  // already valid during the READ cycle; they hold until the next handshake.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      op_q   <= OP_NOP;
      imm_q  <= 8'h00;
      sa_q   <= 3'd0;
      sb_q   <= 3'd0;
      dr_q   <= 3'd0;
      opa_q  <= 8'h00;
      opb_q  <= 8'h00;
      dout_q <= 8'h00;
      fz_q   <= 1'b0;
      fc_q   <= 1'b0;
    end else begin
      if (hs) begin
        op_q  <= INSTR[OP_MSB -: 4];
        imm_q <= INSTR[IMM_MSB -: 8];
        dr_q  <= INSTR[DEST_MSB -: 3];
        sa_q  <= INSTR[SRCA_MSB -: 3];
        sb_q  <= INSTR[SRCB_MSB -: 3];
      end
      if (state_q == ST_READ) begin
        opa_q <= DATA_A;
        opb_q <= DATA_B;
      end
      if (state_q == ST_EXEC) begin
        dout_q <= alu_result;
        if (alu_upd) begin
          fz_q <= (alu_result == 8'h00);
          fc_q <= alu_carry;
        end
      end
    end
  end

  assign SA     = sa_q;
  assign SB     = sb_q;
  assign DR     = dr_q;
  assign D_OUT  = dout_q;
  assign FLAG_Z = fz_q;
  assign FLAG_C = fc_q;

  // op_q is stable throughout WRITE, so these strobes come from registers only.
  assign DONE = (state_q == ST_WRITE);
  assign LD   = DONE && writes_reg(op_q);
  assign ERR  = DONE && alu_illegal;

endmodule

// File: tb/tb_regfile_sequencer.sv
module tb_regfile_sequencer;

  logic        CLK;
  logic        RESET_N;
  logic [15:0] INSTR;
  logic        INSTR_VALID;
  logic        INSTR_READY;
  logic [2:0]  SA, SB, DR;
  logic        LD;
  logic [7:0]  D_OUT;
  logic [7:0]  DATA_A, DATA_B;
  logic        DONE, FLAG_Z, FLAG_C, ERR;

  int n_cmp  = 0;
  int n_fail = 0;

  // Behavioural register file: combinational read, write on LD at the edge.
  logic [7:0] rf [8];

  assign DATA_A = rf[SA];
  assign DATA_B = rf[SB];

  always @(posedge CLK) begin
    if (LD) rf[DR] <= D_OUT;
  end

  regfile_sequencer dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .INSTR       (INSTR),
    .INSTR_VALID (INSTR_VALID),
    .INSTR_READY (INSTR_READY),
    .SA          (SA),
    .SB          (SB),
    .DR          (DR),
    .LD          (LD),
    .D_OUT       (D_OUT),
    .DATA_A      (DATA_A),
    .DATA_B      (DATA_B),
    .DONE        (DONE),
    .FLAG_Z      (FLAG_Z),
    .FLAG_C      (FLAG_C),
    .ERR         (ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [15:0] instr;
    logic        ld;
    logic        err;
    logic [2:0]  dr;
    logic [7:0]  dout;
    logic        z;
    logic        c;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present an instruction (caller is just after a falling edge) and return
  // the time of the accepting rising edge.
  task automatic issue(input logic [15:0] ins, output time hs_t);
    int tries;
    INSTR       = ins;
    INSTR_VALID = 1'b1;
    tries       = 0;
    while (!INSTR_READY && tries < 8) begin
      @(negedge CLK);
      tries++;
    end
    chk("ready_wait", {31'd0, INSTR_READY}, 32'd1);
    @(posedge CLK);
    hs_t = $time;
    #1;
    INSTR_VALID = 1'b0;
    INSTR       = 16'hFFFF;
  endtask

  // Count falling edges until DONE; leaves caller at the WRITE-cycle negedge.
  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge CLK);
      lat++;
    end while (!DONE && lat < 8);
  endtask

  function automatic vec_t mk(input logic [15:0] i, input logic ld, input logic err,
                              input logic [2:0] dr, input logic [7:0] d,
                              input logic z, input logic c);
    vec_t v;
    v.instr = i; v.ld = ld; v.err = err; v.dr = dr; v.dout = d; v.z = z; v.c = c;
    return v;
  endfunction

  initial begin
    time   hs_t, prev_t;
    int    lat;
    logic [7:0] exp_rf [8];

    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    INSTR       = 16'h0000;
    INSTR_VALID = 1'b0;
    RESET_N     = 1'b0;

    //                 instr     ld    err   dr    dout   z     c
    vecs[0]  = mk(16'h765A, 1'b1, 1'b0, 3'd3, 8'h5A, 1'b0, 1'b0); // LDI r3,5A
    vecs[1]  = mk(16'h72F0, 1'b1, 1'b0, 3'd1, 8'hF0, 1'b0, 1'b0); // LDI r1,F0
    vecs[2]  = mk(16'h7420, 1'b1, 1'b0, 3'd2, 8'h20, 1'b0, 1'b0); // LDI r2,20
    vecs[3]  = mk(16'h2850, 1'b1, 1'b0, 3'd4, 8'h10, 1'b0, 1'b1); // ADD r4,r1,r2
    vecs[4]  = mk(16'h7220, 1'b1, 1'b0, 3'd1, 8'h20, 1'b0, 1'b1); // LDI r1,20
    vecs[5]  = mk(16'h3A50, 1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0); // SUB r5,r1,r2
    vecs[6]  = mk(16'h7230, 1'b1, 1'b0, 3'd1, 8'h30, 1'b1, 1'b0); // LDI r1,30
    vecs[7]  = mk(16'h3C88, 1'b1, 1'b0, 3'd6, 8'hF0, 1'b0, 1'b1); // SUB r6,r2,r1
    vecs[8]  = mk(16'h7281, 1'b1, 1'b0, 3'd1, 8'h81, 1'b0, 1'b1); // LDI r1,81
    vecs[9]  = mk(16'h9E40, 1'b1, 1'b0, 3'd7, 8'h40, 1'b0, 1'b1); // SHR r7,r1
    vecs[10] = mk(16'h11C0, 1'b1, 1'b0, 3'd0, 8'h40, 1'b0, 1'b1); // MOV r0,r7
    vecs[11] = mk(16'h44E0, 1'b1, 1'b0, 3'd2, 8'h10, 1'b0, 1'b0); // AND r2,r3,r4
    vecs[12] = mk(16'h5230, 1'b1, 1'b0, 3'd1, 8'hF0, 1'b0, 1'b0); // OR r1,r0,r6
    vecs[13] = mk(16'h66D8, 1'b1, 1'b0, 3'd3, 8'h00, 1'b1, 1'b0); // XOR r3,r3,r3
    vecs[14] = mk(16'h8840, 1'b1, 1'b0, 3'd4, 8'hE0, 1'b0, 1'b1); // SHL r4,r1
    vecs[15] = mk(16'hC200, 1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b1); // illegal 0xC
    vecs[16] = mk(16'h0E00, 1'b0, 1'b0, 3'd7, 8'h00, 1'b0, 1'b1); // NOP
    vecs[17] = mk(16'h2B20, 1'b1, 1'b0, 3'd5, 8'hC0, 1'b0, 1'b1); // ADD r5,r4,r4

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_ready", {31'd0, INSTR_READY}, 32'd1);
    chk("rst_ld",    {31'd0, LD},   32'd0);
    chk("rst_done",  {31'd0, DONE}, 32'd0);
    chk("rst_err",   {31'd0, ERR},  32'd0);
    chk("rst_sel",   {23'd0, SA, SB, DR}, 32'd0);
    chk("rst_dout",  {24'd0, D_OUT}, 32'd0);
    chk("rst_flags", {30'd0, FLAG_Z, FLAG_C}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    @(negedge CLK);

    // Table: back-to-back issue, each taken in the previous WRITE cycle.
    prev_t = 0;
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].instr, hs_t);
      if (i > 0) chk($sformatf("v%0d_spacing", i), 32'(hs_t - prev_t), 32'd30);
      prev_t = hs_t;
      wait_done(lat);
      chk($sformatf("v%0d_latency", i), lat, 32'd3);
      chk($sformatf("v%0d_done", i), {31'd0, DONE}, 32'd1);
      chk($sformatf("v%0d_ld", i),   {31'd0, LD},   {31'd0, vecs[i].ld});
      chk($sformatf("v%0d_err", i),  {31'd0, ERR},  {31'd0, vecs[i].err});
      if (vecs[i].ld) begin
        chk($sformatf("v%0d_dr", i),   {29'd0, DR},    {29'd0, vecs[i].dr});
        chk($sformatf("v%0d_dout", i), {24'd0, D_OUT}, {24'd0, vecs[i].dout});
      end
      chk($sformatf("v%0d_flags", i), {30'd0, FLAG_Z, FLAG_C},
          {30'd0, vecs[i].z, vecs[i].c});
    end

    // Register file after the table; r1 and r7 show illegal/NOP did not write.
    exp_rf = '{8'h40, 8'hF0, 8'h10, 8'h00, 8'hE0, 8'hC0, 8'hF0, 8'h40};
    @(posedge CLK);
    #1;
    for (int r = 0; r < 8; r++)
      chk($sformatf("rf%0d", r), {24'd0, rf[r]}, {24'd0, exp_rf[r]});

    // Idle path
    @(negedge CLK);
    @(negedge CLK);
    chk("idle_ready", {31'd0, INSTR_READY}, 32'd1);
    chk("idle_done",  {31'd0, DONE}, 32'd0);

    // Reset during EXEC of ADD r4,r1,r2 (F0+10 would write 00 with carry)
    issue(16'h2850, hs_t);
    @(negedge CLK);
    @(negedge CLK);
    #1;
    RESET_N = 1'b0;
    #1;
    chk("mid_rst_ld",    {31'd0, LD},   32'd0);
    chk("mid_rst_done",  {31'd0, DONE}, 32'd0);
    chk("mid_rst_err",   {31'd0, ERR},  32'd0);
    chk("mid_rst_sel",   {23'd0, SA, SB, DR}, 32'd0);
    chk("mid_rst_dout",  {24'd0, D_OUT}, 32'd0);
    chk("mid_rst_flags", {30'd0, FLAG_Z, FLAG_C}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("rst_hold%0d_ld", k), {31'd0, LD}, 32'd0);
    end
    RESET_N = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLK);
      chk($sformatf("post_rst%0d_ld", k), {31'd0, LD}, 32'd0);
    end
    chk("post_rst_ready", {31'd0, INSTR_READY}, 32'd1);
    chk("post_rst_rf4",   {24'd0, rf[4]}, 32'hE0);

    // Next instruction retires normally
    issue(16'h7433, hs_t);
    wait_done(lat);
    chk("ldi_latency", lat, 32'd3);
    chk("ldi_ld",    {31'd0, LD}, 32'd1);
    chk("ldi_dr",    {29'd0, DR}, 32'd2);
    chk("ldi_dout",  {24'd0, D_OUT}, 32'h33);
    chk("ldi_flags", {30'd0, FLAG_Z, FLAG_C}, 32'd0);
    @(posedge CLK);
    #1;
    chk("ldi_rf2", {24'd0, rf[2]}, 32'h33);
    chk("ldi_done_drop", {31'd0, DONE}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
